// File: rtl/y_pc_seq.sv
// Program-counter sequencer feeding yIF: selects the next PC from opcode/zero/imm/jTarget,
// counts retired instructions and halts on a programmed count or an unsupported opcode.
module y_pc_seq #(
    parameter logic [31:0] ENTRY   = 32'h28,
    parameter int unsigned MAX_INS = 43
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [31:0] jTarget,
    input  logic        stall,
    output logic [31:0] PC,
    output logic [31:0] PCp4,
    output logic [15:0] count,
    output logic        halted,
    output logic        illegal,
    output logic        redirect
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_INS);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [15:0] r_count, w_count_nxt;
    logic        r_illegal, w_illegal_nxt;

    logic [6:0]  w_op;
    logic        w_legal, w_sb, w_uj;
    logic [31:0] w_pcp4, w_target;
    logic [15:0] w_count_inc;

    assign w_op        = ins[6:0];
    assign w_pcp4      = r_pc + 32'd4;
    assign w_count_inc = r_count + 16'd1;

    // Opcodes with X/Z bits match no item and fall into the illegal default.
    always_comb begin
        w_legal = 1'b0;
        w_sb    = 1'b0;
        w_uj    = 1'b0;
        case (w_op)
            7'h33, 7'h03, 7'h13, 7'h23: w_legal = 1'b1;
            7'h63: begin
                w_legal = 1'b1;
                w_sb    = 1'b1;
            end
            7'h6f: begin
                w_legal = 1'b1;
                w_uj    = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_target = w_pcp4;
        if (w_sb && zero) begin
            w_target = w_pcp4 + (imm << 2);
        end else if (w_uj) begin
            w_target = w_pcp4 + (jTarget << 2);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_count_nxt   = r_count;
        w_illegal_nxt = r_illegal;
        if (r_state == S_RUN && !stall) begin
            if (w_legal) begin
                w_pc_nxt    = w_target;
                w_count_nxt = w_count_inc;
                if (MAX_INS != 0 && w_count_inc == MAX_CNT) begin
                    w_state_nxt = S_HALT;
                end
            end else begin
                w_illegal_nxt = 1'b1;
                w_state_nxt   = S_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_pc      <= ENTRY;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_count   <= w_count_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign PC       = r_pc;
    assign PCp4     = w_pcp4;
    assign count    = r_count;
    assign halted   = (r_state == S_HALT);
    assign illegal  = r_illegal;
    assign redirect = (w_sb && zero) || w_uj;

endmodule
